dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the CPU (LW/SW from ControlSignals) and the init-time loader.
//  Owns the data-memory page register (incrementPage/decrementPage) and forms {page, offset} addresses.
//  Sequences multi-cycle reads and stalls the CPU until LW data returns. Sits between Control/datapath and data memory.
// PARAMETERS
//  DATA_W  8  data word width
//  PAGE_W  2  page register width; 2**PAGE_W pages
//  OFF_W   6  in-page offset width; mem address width = PAGE_W+OFF_W
//  RD_LAT  1  memory read latency in cycles (legal 1..4); rdata valid RD_LAT cycles after mem_en&!mem_we
// PORTS
//  clk         in   1       clock, rising edge
//  rst_n       in   1       async active-low reset
//  init        in   1       1: loader owns memory, CPU ignored
//  cpu_rd      in   1       ctrl.memRead
//  cpu_wr      in   1       ctrl.memWrite
//  cpu_off     in   OFF_W   CPU in-page offset
//  cpu_wdata   in   DATA_W  SW data
//  inc_page    in   1       ctrl.incrementPage
//  dec_page    in   1       ctrl.decrementPage
//  cpu_rdata   out  DATA_W  LW data, valid when cpu_rvalid
//  cpu_rvalid  out  1       1-cycle pulse: LW data returned
//  cpu_stall   out  1       hold PC/pipeline this cycle
//  page        out  PAGE_W  current page
//  ld_req      in   1       loader request (held until ld_gnt)
//  ld_we       in   1       loader write(1)/read(0)
//  ld_addr     in   PAGE_W+OFF_W  loader full address
//  ld_wdata    in   DATA_W  loader write data
//  ld_gnt      out  1       1-cycle pulse: loader access issued
//  ld_rvalid   out  1       1-cycle pulse: loader read data valid (data on ld_rdata)
//  ld_rdata    out  DATA_W  loader read data
//  mem_en, mem_we  out  1   memory strobe / write enable
//  mem_addr    out  PAGE_W+OFF_W  memory address
//  mem_wdata   out  DATA_W  memory write data
//  mem_rdata   in   DATA_W  memory read data
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, page=0, cnt=0; every output 0 (cpu_stall forced 0).
//  FSM IDLE/CPU_RD/LD_RD; cnt counts down RD_LAT-1..0 in the read states.
//  IDLE, init=0: cpu_wr -> issue write {page,cpu_off}, stay IDLE, no stall. cpu_rd -> issue read, cpu_stall=1, ->CPU_RD.
//   No CPU request and ld_req -> issue loader access, ld_gnt=1; read ->LD_RD, write stays IDLE. CPU wins on conflict.
//  IDLE, init=1: CPU inputs ignored, cpu_stall=0; ld_req issued every cycle it is asserted as above.
//  CPU_RD: no issue; cpu_stall=1 while cnt!=0; at cnt==0: cpu_rvalid=1, cpu_stall=0, cpu_rdata=mem_rdata, ->IDLE.
//  LD_RD: no issue; at cnt==0: ld_rvalid=1, ld_rdata=mem_rdata, ->IDLE. If init=0 and cpu_rd/cpu_wr: cpu_stall=1.
//  Next access issues no earlier than the cycle after a read completes (one bubble per read).
//  cpu_rd&cpu_wr together: illegal (assertion); write wins.
//  Page: updates at clk edge when !cpu_stall&!init; inc wraps max->0, dec wraps 0->max; inc&dec -> no change.
//   Access in same cycle uses old page. init=1 holds page at 0.
//  init toggling mid-read: in-flight read completes normally (rvalid to original requester); new owner waits.
//  rst_n low mid-read: read abandoned, no rvalid, state IDLE.
//  cpu_rdata/ld_rdata hold 0 when their rvalid=0.
// STRUCTURE
//  Defs package: arb_state_t {IDLE,CPU_RD,LD_RD}; RD_LAT_MAX=4 constant.
//  Sub-module page_reg (wrapping up/down counter, enable, sync clear on init).
//  Top: FSM + cnt + issue mux; combinational outputs from state/cnt/inputs.
// TESTING
//  Reset: rst_n=0 mid-CPU_RD -> all outputs 0, page=0; release -> IDLE, no spurious rvalid.
//  CPU SW then LW, RD_LAT=1, page=2, off=5: write at 0x85; LW stall 1 cycle, rvalid next cycle, rdata=written.
//  RD_LAT=3 LW: cpu_stall high exactly 3 cycles, rvalid 1 cycle, one bubble before next access.
//  Page wrap: 4x inc_page from 3 -> 3,0,1,2,3; dec at 0 -> 3; inc&dec -> unchanged; inc during stall ignored.
//  init=1 loader writes 0x00..0x0F with data=addr, then reads 0x0A -> ld_gnt each issue, ld_rvalid, ld_rdata=0x0A.
//  Conflict init=0: cpu_rd and ld_req same cycle -> CPU issued, ld_gnt waits until IDLE with no CPU request.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// read-latency limits and the latency-to-counter conversion.
package dmem_arbiter_pkg;

  // Arbiter FSM states: idle (may issue), CPU read in flight, loader read in flight.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CPU_RD = 2'd1,
    LD_RD  = 2'd2
  } arb_state_t;

  // Largest supported memory read latency and the counter width it needs.
  localparam int RD_LAT_MAX = 4;
  localparam int CNT_W      = $clog2(RD_LAT_MAX);

  // Starting value of the read countdown; the counter reaches 0 in the
  // cycle the memory data becomes valid.
  function automatic logic [CNT_W-1:0] lat_to_cnt(input int lat);
    return CNT_W'(lat - 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_page_reg.sv
// Data-memory page register: wrapping up/down counter with an update
// enable and a synchronous clear that dominates everything else.
module dmem_arbiter_page_reg #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] page
);

  // Page update: clear wins, then a single inc or dec when enabled.
  // Modular arithmetic gives the max->0 and 0->max wrap for free.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering in simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      page <= '0;
    end else if (clr) begin
      page <= '0;
    end else if (en && inc && !dec) begin
      page <= page + W'(1);
    end else if (en && dec && !inc) begin
      page <= page - W'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares the single-port data memory between the CPU
// load/store path and the init-time loader, owns the page register, forms
// {page, offset} addresses and stalls the CPU until load data returns.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PAGE_W = 2,
  parameter int OFF_W  = 6,
  parameter int RD_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    init,
  // CPU side
  input  logic                    cpu_rd,
  input  logic                    cpu_wr,
  input  logic [OFF_W-1:0]        cpu_off,
  input  logic [DATA_W-1:0]       cpu_wdata,
  input  logic                    inc_page,
  input  logic                    dec_page,
  output logic [DATA_W-1:0]       cpu_rdata,
  output logic                    cpu_rvalid,
  output logic                    cpu_stall,
  output logic [PAGE_W-1:0]       page,
  // Loader side
  input  logic                    ld_req,
  input  logic                    ld_we,
  input  logic [PAGE_W+OFF_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]       ld_wdata,
  output logic                    ld_gnt,
  output logic                    ld_rvalid,
  output logic [DATA_W-1:0]       ld_rdata,
  // Memory side
  output logic                    mem_en,
  output logic                    mem_we,
  output logic [PAGE_W+OFF_W-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cpu_req;
  logic             page_en;

  // The CPU only competes for the memory when the loader does not own it.
  assign cpu_req = !init && (cpu_rd || cpu_wr);

  // Page moves only when the CPU actually advances; init pins it to page 0.
  assign page_en = !cpu_stall && !init;

  dmem_arbiter_page_reg #(
    .W (PAGE_W)
  ) u_page_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (page_en),
    .clr   (init),
    .inc   (inc_page),
    .dec   (dec_page),
    .page  (page)
  );

  // FSM state and read-latency countdown registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, issue mux and handshake outputs.
  // NOTE: every signal written here gets a default before any branch, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    cpu_stall  = 1'b0;
    cpu_rvalid = 1'b0;
    cpu_rdata  = '0;
    ld_gnt     = 1'b0;
    ld_rvalid  = 1'b0;
    ld_rdata   = '0;

    // Outputs stay at 0 for as long as reset is held, whatever the inputs do.
    if (rst_n) begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            // CPU wins any conflict; a simultaneous rd/wr resolves to write.
            mem_en   = 1'b1;
            mem_addr = {page, cpu_off};
            if (cpu_wr) begin
              mem_we    = 1'b1;
              mem_wdata = cpu_wdata;
            end else begin
              cpu_stall = 1'b1;
              cnt_d     = lat_to_cnt(RD_LAT);
              state_d   = CPU_RD;
            end
          end else if (ld_req) begin
            mem_en   = 1'b1;
            mem_we   = ld_we;
            mem_addr = ld_addr;
            ld_gnt   = 1'b1;
            if (ld_we) begin
              mem_wdata = ld_wdata;
            end else begin
              cnt_d   = lat_to_cnt(RD_LAT);
              state_d = LD_RD;
            end
          end
        end

        CPU_RD: begin
          // The completion cycle issues nothing: it is the bubble after a read.
          if (cnt_q != '0) begin
            cpu_stall = 1'b1;
            cnt_d     = cnt_q - CNT_W'(1);
          end else begin
            cpu_rvalid = 1'b1;
            cpu_rdata  = mem_rdata;
            state_d    = IDLE;
          end
        end

        LD_RD: begin
          // A CPU access arriving while the loader read is in flight must wait.
          cpu_stall = cpu_req;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            ld_rvalid = 1'b1;
            ld_rdata  = mem_rdata;
            state_d   = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // The control decoder never asserts load and store together.
  a_no_cpu_rd_wr: assert property (
    @(posedge clk) disable iff (!rst_n) !(cpu_rd && cpu_wr && !init)
  );

  // The countdown counter is sized for latencies 1..RD_LAT_MAX only.
  a_rd_lat_range: assert property (
    @(posedge clk) disable iff (!rst_n) (RD_LAT >= 1) && (RD_LAT <= RD_LAT_MAX)
  );

endmodule
